tone_pwm_engine: RTL and testbench
==================================

# tone_pwm_engine

Tone responder for the note sequencer's `freq`/`duration`/`enable`/`done` handshake. It latches one note request, computes the square-wave half-period with an iterative divider, and plays a 50% duty tone on `pwm_out` for the requested number of milliseconds. It then holds `done` until the sequencer drops `enable`. It sits between the sequencer state machine and the speaker pin.

## Interface
- `CLK_HZ`, default 100_000_000: system clock frequency in Hz. Must be a multiple of 1000, at least 2000, and below 2^32.
- `MS_TICKS`, default CLK_HZ/1000: clock cycles per millisecond. Derived; not overridden independently.

Ports:
- `clk` in 1: system clock. One clock domain; all logic is on the rising edge.
- `reset` in 1: synchronous, active-high reset.
- `freq` in 32: tone frequency in Hz. 0 means a rest (silent for the full duration).
- `duration` in 32: note length in milliseconds.
- `enable` in 1: request level, held high by the sequencer for the whole note.
- `done` out 1: note complete. Held high until `enable` is low.
- `pwm_out` out 1: square-wave tone output, registered.

## Operation
- States: IDLE, CALC, PLAY, DONE.
- **Reset:** state goes to IDLE; `pwm_out`=0, `done`=0; all counters and latches are cleared. Reset mid-note takes effect on the next edge, and `pwm_out` is 0 after it.
- **IDLE:** `pwm_out`=0, `done`=0. When `enable` is sampled high, latch `freq` and `duration`, clear the counters, and go to CALC. Input changes after the latch are ignored until the engine returns to IDLE.
- **CALC:** runs a restoring shift-subtract divide of CLK_HZ by (2×freq_latched), using a 33-bit divisor and producing a 32-bit quotient.
  - It always takes exactly 32 cycles, including when freq=0.
  - half_period = quotient, clamped to a minimum of 1. For freq=0, half_period is don't-care and the output stays silent.
  - On completion: if duration_latched=0, go to DONE. Otherwise go to PLAY with `pwm_out`=1, or `pwm_out`=0 when freq=0.
- **PLAY:**
  - The half counter counts 0..half_period-1. On wrap, `pwm_out` toggles; freq=0 suppresses the toggle.
  - The ms prescaler counts 0..MS_TICKS-1. On its wrap, the ms counter increments.
  - When the ms counter reaches duration_latched, go to DONE. PLAY therefore lasts exactly duration×MS_TICKS cycles.
- **DONE:** `pwm_out`=0, `done`=1. Stay while `enable`=1. When `enable`=0, go to IDLE, and `done` falls on that edge.
- **Abort:** `enable`=0 sampled in CALC or PLAY sends the engine to IDLE on the next edge, with `pwm_out`=0 and `done` never asserted. A later rise of `enable` restarts the note from CALC with freshly latched inputs.
- **Width rules:**
  - 2×freq is computed in 33 bits, so there is no overflow.
  - freq > CLK_HZ/2 yields quotient 0, which is clamped to 1. The output then toggles every cycle.
  - The ms counter is 32-bit and compared with equality.

## Timing
- Edge E samples `enable`=1 in IDLE.
- Edges E+1..E+32 are CALC.
- Edge E+33 enters PLAY; `pwm_out` rises on edge E+33 when freq≠0.
- `pwm_out` high and low phases are each exactly half_period cycles. An odd split is truncated by the floor division.
- DONE is entered on edge E+33+duration×MS_TICKS, where `done` rises and `pwm_out` is forced to 0.
- Request-to-`done` latency is 33 + duration×MS_TICKS cycles.
- `done` falls on the first edge that samples `enable`=0. The next note can be sampled no earlier than the following edge.
- The sequencer's one-cycle `enable` drop between notes is sufficient to re-arm.

## Test plan
1. **Basic tone:** CLK_HZ=100_000, freq=1000, duration=2, `enable` held high.
   - `pwm_out` shows 50 cycles high, 50 low, 50 high, 50 low, starting at E+33.
   - `done` rises at E+233 with `pwm_out`=0.
   - `enable` low → `done`=0 on the next edge.
2. **Rest and zero length:** CLK_HZ=100_000.
   - freq=0, duration=1: `pwm_out` stays 0 throughout and `done` rises at E+133.
   - freq=500, duration=0: `done` rises at E+33 and `pwm_out` is never 1.
3. **Clamp:** CLK_HZ=100_000, freq=60_000 (quotient 0 → 1), duration=1. `pwm_out` toggles every cycle for 100 cycles, then `done` rises.
4. **Abort and restart:** CLK_HZ=100_000, freq=1000, duration=2; drop `enable` at E+80.
   - `pwm_out`=0 from the next edge and `done` stays 0.
   - Re-raise `enable` with freq=2000: the new tone has 25-cycle half-periods and restarts 33 cycles after the new sample.
5. **Back-to-back with the sequencer:** drive eight notes of duration 1, with `enable` dropped for one cycle after each `done`. Check each note's half_period against CLK_HZ/(2×freq) and the total cycle count.
6. **Reset mid-PLAY:** assert `reset` for one cycle during a high phase. `pwm_out`=0 and `done`=0 from the next edge, and the engine sits in IDLE until `enable` is sampled high again.

Source files
------------

// File: rtl/tone_pwm_engine.sv
// tone_pwm_engine
//
// Plays one note for the sequencer's freq/duration/enable/done handshake.
// A request is latched in IDLE. CALC then derives the square-wave half-period
// as CLK_HZ / (2*freq) with a bit-serial restoring divider. PLAY emits a 50%
// duty tone for duration milliseconds. DONE holds `done` until `enable` drops.
//
// Parameters:
//   CLK_HZ    system clock in Hz (multiple of 1000, >= 2000, < 2^32)
//   MS_TICKS  clock cycles per millisecond (derived from CLK_HZ)
//
// Ports:
//   clk       system clock, rising edge
//   reset     synchronous, active-high
//   freq      tone frequency in Hz, 0 = rest
//   duration  note length in milliseconds
//   enable    request level, held high for the whole note
//   done      note complete, held until enable is low
//   pwm_out   registered square-wave output

module tone_pwm_engine #(
    parameter int unsigned CLK_HZ   = 100_000_000,
    parameter int unsigned MS_TICKS = CLK_HZ / 1000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] freq,
    input  logic [31:0] duration,
    input  logic        enable,
    output logic        done,
    output logic        pwm_out
);

    localparam logic [31:0] DIVIDEND = 32'(CLK_HZ);
    localparam logic [31:0] MS_LAST  = 32'(MS_TICKS - 1);

    typedef enum logic [1:0] {ST_IDLE, ST_CALC, ST_PLAY, ST_DONE} state_t;

    state_t      state;
    logic [31:0] freq_l;
    logic [31:0] dur_l;
    logic [31:0] dvd_sh;       // dividend bits, MSB first
    logic [32:0] rem;          // partial remainder, always < divisor
    logic [31:0] quo;
    logic [5:0]  step;         // 0..31 divide steps, 32 = finalize
    logic [31:0] half_period;
    logic [31:0] half_cnt;
    logic [31:0] ms_pre;
    logic [31:0] ms_cnt;

    // One restoring divide step. The divisor 2*freq needs 33 bits, and the
    // shifted remainder needs one more bit than that.
    logic [33:0] divisor;
    logic [33:0] trial;
    logic        take;
    logic [33:0] diff;
    logic [32:0] rem_next;
    logic [31:0] quo_next;

    always_comb begin
        divisor  = {1'b0, freq_l, 1'b0};
        trial    = {rem, dvd_sh[31]};
        take     = (trial >= divisor);
        diff     = trial - divisor;
        rem_next = take ? diff[32:0] : trial[32:0];
        quo_next = {quo[30:0], take};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_IDLE;
            freq_l      <= '0;
            dur_l       <= '0;
            dvd_sh      <= '0;
            rem         <= '0;
            quo         <= '0;
            step        <= '0;
            half_period <= '0;
            half_cnt    <= '0;
            ms_pre      <= '0;
            ms_cnt      <= '0;
            pwm_out     <= 1'b0;
            done        <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    pwm_out <= 1'b0;
                    done    <= 1'b0;
                    if (enable) begin
                        freq_l   <= freq;
                        dur_l    <= duration;
                        dvd_sh   <= DIVIDEND;
                        rem      <= '0;
                        quo      <= '0;
                        step     <= '0;
                        half_cnt <= '0;
                        ms_pre   <= '0;
                        ms_cnt   <= '0;
                        state    <= ST_CALC;
                    end
                end

                ST_CALC: begin
                    if (!enable) begin
                        pwm_out <= 1'b0;
                        state   <= ST_IDLE;
                    end else if (step == 6'd32) begin
                        // Frequencies above CLK_HZ/2 divide to 0; toggle every cycle.
                        half_period <= (quo == 32'd0) ? 32'd1 : quo;
                        if (dur_l == 32'd0) begin
                            pwm_out <= 1'b0;
                            done    <= 1'b1;
                            state   <= ST_DONE;
                        end else begin
                            pwm_out <= (freq_l != 32'd0);
                            state   <= ST_PLAY;
                        end
                    end else begin
                        rem    <= rem_next;
                        quo    <= quo_next;
                        dvd_sh <= {dvd_sh[30:0], 1'b0};
                        step   <= step + 6'd1;
                    end
                end

                ST_PLAY: begin
                    if (!enable) begin
                        pwm_out <= 1'b0;
                        state   <= ST_IDLE;
                    end else begin
                        if (half_cnt == half_period - 32'd1) begin
                            half_cnt <= '0;
                            if (freq_l != 32'd0)
                                pwm_out <= ~pwm_out;
                        end else begin
                            half_cnt <= half_cnt + 32'd1;
                        end

                        if (ms_pre == MS_LAST) begin
                            ms_pre <= '0;
                            ms_cnt <= ms_cnt + 32'd1;
                            // Ending on this wrap makes PLAY last exactly
                            // duration*MS_TICKS cycles; the later assignment
                            // overrides any toggle in the same cycle.
                            if (ms_cnt + 32'd1 == dur_l) begin
                                pwm_out <= 1'b0;
                                done    <= 1'b1;
                                state   <= ST_DONE;
                            end
                        end else begin
                            ms_pre <= ms_pre + 32'd1;
                        end
                    end
                end

                ST_DONE: begin
                    pwm_out <= 1'b0;
                    if (!enable) begin
                        done  <= 1'b0;
                        state <= ST_IDLE;
                    end else begin
                        done <= 1'b1;
                    end
                end

                default: begin
                    pwm_out <= 1'b0;
                    done    <= 1'b0;
                    state   <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tone_pwm_engine.sv
// Testbench for tone_pwm_engine at CLK_HZ = 100_000 (100 cycles per ms).
// A reference model predicts pwm_out/done for every cycle after a request
// directly from the note's timing rules. A vector table adds latency and
// high-cycle totals. Hand-written sequences cover abort, reset and
// back-to-back notes.

`timescale 1ns/1ps

module tb_tone_pwm_engine;

    localparam int unsigned CLK = 100_000;
    localparam int unsigned MS  = 100;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] freq;
    logic [31:0] duration;
    logic        enable;
    logic        done;
    logic        pwm_out;

    int n_checks = 0;
    int n_pass   = 0;
    int unsigned cyc = 0;
    int unsigned e_cyc;

    tone_pwm_engine #(.CLK_HZ(CLK)) dut (
        .clk      (clk),
        .reset    (reset),
        .freq     (freq),
        .duration (duration),
        .enable   (enable),
        .done     (done),
        .pwm_out  (pwm_out)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input longint act, input longint exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, required %0d (time %0t)", name, act, exp, $time);
    endtask

    // Reference model: output t cycles after the request edge E.
    function automatic logic model_pwm(longint f, longint d, longint t);
        longint hp;
        if (f == 0) return 1'b0;
        if (t < 33 || t >= 33 + d * MS) return 1'b0;
        hp = CLK / (2 * f);
        if (hp == 0) hp = 1;
        return (((t - 33) / hp) % 2) == 0;
    endfunction

    function automatic logic model_done(longint d, longint t);
        return t >= 33 + d * MS;
    endfunction

    // Issue one note. Check every cycle from E up to the expected done edge.
    // The bench scribbles on freq/duration after E to show that they were latched.
    task automatic run_note(input logic [31:0] f, input logic [31:0] d,
                            output int lat, output int highs);
        longint tmax;
        @(negedge clk);
        freq = f; duration = d; enable = 1'b1;
        @(posedge clk);
        #1;
        e_cyc = cyc;
        chk("calc_pwm_t0", pwm_out, 0);
        chk("calc_done_t0", done, 0);
        freq = $urandom; duration = $urandom_range(1, 9);
        lat = -1; highs = 0;
        tmax = 33 + longint'(d) * MS;
        for (longint t = 1; t <= tmax; t++) begin
            @(posedge clk);
            #1;
            chk($sformatf("pwm f=%0d t=%0d", f, t), pwm_out, model_pwm(f, d, t));
            chk($sformatf("done f=%0d t=%0d", f, t), done, model_done(d, t));
            if (pwm_out) highs++;
            if (done && lat < 0) lat = int'(t);
        end
    endtask

    // Drop enable for one edge. done must fall on that edge.
    task automatic finish_note();
        @(negedge clk);
        enable = 1'b0;
        @(posedge clk);
        #1;
        chk("done_fall", done, 0);
        chk("pwm_after_done", pwm_out, 0);
    endtask

    typedef struct {
        logic [31:0] f;
        logic [31:0] d;
        int          lat;
        int          highs;
    } vec_t;

    vec_t vecs[$];

    initial begin
        int lat, highs;
        int unsigned first_e;

        vecs.push_back('{32'd1000,       32'd2, 233, 100}); // 50/50 pattern, two periods
        vecs.push_back('{32'd0,          32'd1, 133, 0});   // rest
        vecs.push_back('{32'd500,        32'd0, 33,  0});   // zero length
        vecs.push_back('{32'd60000,      32'd1, 133, 50});  // clamp to 1
        vecs.push_back('{32'd2000,       32'd1, 133, 50});
        vecs.push_back('{32'hFFFF_FFFF,  32'd1, 133, 50});  // 2*freq needs 33 bits
        vecs.push_back('{32'd1,          32'd1, 133, 100}); // half period longer than note
        vecs.push_back('{32'd700,        32'd1, 133, 71});  // truncated half period 71
        vecs.push_back('{32'd50000,      32'd1, 133, 50});  // exactly CLK/2

        reset = 1'b1; enable = 1'b0; freq = '0; duration = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_pwm", pwm_out, 0);
        chk("reset_done", done, 0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        chk("idle_pwm", pwm_out, 0);
        chk("idle_done", done, 0);

        // Vector table
        foreach (vecs[i]) begin
            run_note(vecs[i].f, vecs[i].d, lat, highs);
            chk($sformatf("latency vec%0d", i), lat, vecs[i].lat);
            chk($sformatf("high_cycles vec%0d", i), highs, vecs[i].highs);
            // done must hold while enable stays high
            @(posedge clk);
            #1;
            chk($sformatf("done_hold vec%0d", i), done, 1);
            finish_note();
        end

        // Abort mid-PLAY, then restart with a new frequency
        @(negedge clk);
        freq = 32'd1000; duration = 32'd2; enable = 1'b1;
        @(posedge clk);
        for (int t = 1; t <= 79; t++) @(posedge clk);
        #1;
        chk("abort_pre_pwm", pwm_out, 1);
        @(negedge clk);
        enable = 1'b0;
        @(posedge clk);
        #1;
        chk("abort_pwm", pwm_out, 0);
        chk("abort_done", done, 0);
        for (int k = 0; k < 4; k++) begin
            @(posedge clk);
            #1;
            chk("abort_idle_pwm", pwm_out, 0);
            chk("abort_idle_done", done, 0);
        end
        run_note(32'd2000, 32'd1, lat, highs);
        chk("restart_latency", lat, 133);
        finish_note();

        // Reset during a high phase
        @(negedge clk);
        freq = 32'd1000; duration = 32'd2; enable = 1'b1;
        @(posedge clk);
        for (int t = 1; t <= 40; t++) @(posedge clk);
        #1;
        chk("rst_pre_pwm", pwm_out, 1);
        @(negedge clk);
        reset = 1'b1; enable = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_pwm", pwm_out, 0);
        chk("rst_done", done, 0);
        @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            #1;
            chk("rst_idle_pwm", pwm_out, 0);
            chk("rst_idle_done", done, 0);
        end
        run_note(32'd1000, 32'd1, lat, highs);
        chk("post_rst_latency", lat, 133);
        finish_note();

        // Eight back-to-back notes, one-cycle enable gaps
        first_e = 0;
        for (int n = 0; n < 8; n++) begin
            logic [31:0] f;
            f = (n == 3) ? 32'd0 : 32'($urandom_range(1, 60000));
            run_note(f, 32'd1, lat, highs);
            if (n == 0) first_e = e_cyc;
            chk($sformatf("b2b_latency n%0d", n), lat, 133);
            if (n == 7) chk("b2b_total_cycles", cyc - first_e, 7 * 135 + 133);
            finish_note();
        end

        // Randomized notes against the model
        for (int n = 0; n < 16; n++) begin
            logic [31:0] f;
            logic [31:0] d;
            case ($urandom_range(0, 7))
                0:       f = 32'd0;
                1:       f = $urandom;
                2:       f = 32'($urandom_range(1, 20));
                default: f = 32'($urandom_range(1, 70000));
            endcase
            d = 32'($urandom_range(0, 2));
            run_note(f, d, lat, highs);
            chk($sformatf("rand_latency n%0d", n), lat, 33 + int'(d) * int'(MS));
            finish_note();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
